// File: rtl/truth_table_capture.sv
// Exhaustive stimulus/response engine: sweeps every input vector of an N-input
// single-output block, captures its truth table and compares it with a reference.
module truth_table_capture #(
    parameter int unsigned N_INPUTS      = 4,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     resp_in,
    input  logic [2**N_INPUTS-1:0]   expected,
    output logic [N_INPUTS-1:0]      stim,
    output logic                     busy,
    output logic                     done,
    output logic [2**N_INPUTS-1:0]   table_out,
    output logic                     match
);

    localparam int unsigned TABLE_W = 2**N_INPUTS;
    localparam int unsigned CNT_W   = 8;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [N_INPUTS-1:0] STIM_LAST   = N_INPUTS'(TABLE_W - 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE_CYCLES);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_INPUTS-1:0] stim_d;
    logic                busy_d;
    logic                done_d;
    logic [TABLE_W-1:0]  table_d;
    logic                match_d;
    logic [TABLE_W-1:0]  sampled;

    // State and output registers; stim doubles as the sweep index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stim      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            table_out <= '0;
            match     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stim      <= stim_d;
            busy      <= busy_d;
            done      <= done_d;
            table_out <= table_d;
            match     <= match_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stim_d  = stim;
        busy_d  = busy;
        done_d  = 1'b0;
        table_d = table_out;
        match_d = match;

        // Table with the current response folded in, used on sampling edges.
        sampled       = table_out;
        sampled[stim] = resp_in;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = HOLD;
                    busy_d  = 1'b1;
                    table_d = '0;
                    match_d = 1'b0;
                    stim_d  = '0;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end

            HOLD: begin
                if (cnt_q < SETTLE_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                    table_d = sampled;
                    if (stim == STIM_LAST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        stim_d  = '0;
                        match_d = (sampled == expected);
                    end else begin
                        stim_d = stim + N_INPUTS'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                stim_d  = '0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench for truth_table_capture: default config (4 inputs, settle 2)
// and a 3-input zero-settle instance, with a scoreboard of expected tables.
module tb_truth_table_capture;

    localparam int N1 = 4;
    localparam int S1 = 2;
    localparam int T1 = 16;
    localparam int LAT1 = T1 * (S1 + 1);
    localparam int N2 = 3;
    localparam int S2 = 0;
    localparam int T2 = 8;
    localparam int LAT2 = T2 * (S2 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          start2;
    logic          resp;
    logic          resp2;
    logic [T1-1:0] expected;
    logic [T2-1:0] expected2;
    logic [N1-1:0] stim;
    logic [N2-1:0] stim2;
    logic          busy, busy2;
    logic          done, done2;
    logic [T1-1:0] table_out;
    logic [T2-1:0] table_out2;
    logic          match, match2;

    logic [T1-1:0] model_tbl = 16'h8DC5;

    // Combinational models of the blocks under test.
    assign resp  = model_tbl[stim];
    assign resp2 = stim2[0] & stim2[2];

    truth_table_capture #(.N_INPUTS(N1), .SETTLE_CYCLES(S1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .resp_in(resp),
        .expected(expected), .stim(stim), .busy(busy), .done(done),
        .table_out(table_out), .match(match)
    );

    truth_table_capture #(.N_INPUTS(N2), .SETTLE_CYCLES(S2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .resp_in(resp2),
        .expected(expected2), .stim(stim2), .busy(busy2), .done(done2),
        .table_out(table_out2), .match(match2)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [16:0] sb[$];  // {match, table}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push1(input logic [T1-1:0] exp_tbl);
        logic [T1-1:0] t;
        for (int k = 0; k < T1; k++) t[k] = model_tbl[k];
        sb.push_back({(t == exp_tbl), t});
    endtask

    task automatic push2(input logic [T2-1:0] exp_tbl);
        logic [T2-1:0] t;
        for (int k = 0; k < T2; k++) begin
            logic [2:0] kv;
            kv   = 3'(k);
            t[k] = kv[0] & kv[2];
        end
        sb.push_back({(t == exp_tbl), 8'h00, t});
    endtask

    task automatic start_edge1();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge after a start edge; follows the sweep to done.
    task automatic wait_done1(input bit abuse, input bit restart);
        int n;
        bit seen;
        logic [16:0] e;
        seen = 1'b0;
        for (n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (n < LAT1) begin
                check("stim_step", 32'(stim), 32'(n / (S1 + 1)));
                check("busy_high", 32'(busy), 32'd1);
            end
            if (abuse && (n == 4 || n == 29)) start = 1'b1;
        end
        e = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
        check("latency", 32'(n), 32'(LAT1));
        check("done_busy", 32'(busy), 32'd0);
        check("done_stim", 32'(stim), 32'd0);
        check("table", 32'(table_out), 32'(e[15:0]));
        check("match", 32'(match), 32'(e[16]));
        if (seen) begin
            if (restart) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            check("done_pulse", 32'(done), 32'd0);
            if (restart) begin
                check("restart_busy", 32'(busy), 32'd1);
                check("restart_table", 32'(table_out), 32'd0);
                check("restart_match", 32'(match), 32'd0);
                check("restart_stim", 32'(stim), 32'd0);
            end else begin
                check("hold_table", 32'(table_out), 32'(e[15:0]));
                check("hold_match", 32'(match), 32'(e[16]));
            end
        end
    endtask

    initial begin
        int n;
        bit any_done;
        logic [16:0] e;

        reset     = 1'b1;
        start     = 1'b0;
        start2    = 1'b0;
        expected  = 16'h8DC5;
        expected2 = 8'hA0;

        // Reset then idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("idle1", {stim, busy, done, table_out, match}, 32'd0);
            check("idle2", {stim2, busy2, done2, table_out2, match2}, 32'd0);
        end

        // Known function with matching reference.
        push1(16'h8DC5);
        start_edge1();
        check("start_busy", 32'(busy), 32'd1);
        check("start_stim", 32'(stim), 32'd0);
        wait_done1(1'b0, 1'b0);

        // Mismatching reference.
        expected = 16'h8DC4;
        push1(16'h8DC4);
        start_edge1();
        wait_done1(1'b0, 1'b0);

        // Start pulses mid-sweep are ignored; start in done cycle restarts.
        expected = 16'h8DC5;
        push1(16'h8DC5);
        push1(16'h8DC5);
        start_edge1();
        wait_done1(1'b1, 1'b1);
        wait_done1(1'b0, 1'b0);

        // Reset in the middle of a sweep.
        start_edge1();
        repeat (19) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_stim", 32'(stim), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_table", 32'(table_out), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        any_done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) any_done = 1'b1;
        end
        check("rst_no_done", 32'(any_done), 32'd0);
        push1(16'h8DC5);
        start_edge1();
        wait_done1(1'b0, 1'b0);

        // 3-input, zero-settle instance.
        push2(8'hA0);
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0;
        for (n = 1; n <= 50; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done2) break;
            check("stim2_step", 32'(stim2), 32'(n));
        end
        e = (sb.size() > 0) ? sb.pop_front() : 17'h1ffff;
        check("latency2", 32'(n), 32'(LAT2));
        check("table2", 32'(table_out2), 32'(e[15:0]));
        check("match2", 32'(match2), 32'(e[16]));
        check("busy2_done", 32'(busy2), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("done2_pulse", 32'(done2), 32'd0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
